pulse_trigger_sequencer: RTL and testbench
==========================================

# pulse_trigger_sequencer

Upstream timing master for the probe-pulse path. Generates the periodic one-cycle `signal_start_o` trigger for the probe-pulse generator, which forms the optical pulse on its rising edge. For each trigger it also produces a matching ADC acquisition gate and trace index, so every captured trace is tied to exactly one probe pulse. Supports finite bursts and continuous free-run, with configuration latched per run.

## Interface
- `CNT_W`, 32, width of all period/delay/length/count/index fields
- `clk_adc_i`  in  1  ADC sample clock; sole clock
- `reset_i`  in  1  synchronous, active-high reset
- `enable_i`  in  1  run request; a rising edge starts a run, a low level stops it
- `period_i`  in  CNT_W  trigger repetition period, clk cycles
- `count_i`  in  CNT_W  triggers per run; 0 = continuous
- `acq_delay_i`  in  CNT_W  cycles from trigger to acquisition-gate start
- `acq_len_i`  in  CNT_W  acquisition-gate length, cycles
- `signal_start_o`  out  1  one-cycle trigger to the pulse generator
- `acq_gate_o`  out  1  high while ADC samples belong to the current trace
- `trace_idx_o`  out  CNT_W  index of the current trace, 0-based per run
- `busy_o`  out  1  run in progress
- `done_o`  out  1  one-cycle strobe when a finite burst completes
- `cfg_err_o`  out  1  last start attempt was rejected (invalid config)

## Operation
- Reset value of all outputs: 0. Reset also clears the internal counters and the `enable_i` edge register, and forces state IDLE. Reset applied mid-run aborts immediately, with no `done_o`.
- States:
  - IDLE → RUN on a valid start.
  - IDLE → IDLE with `cfg_err_o`=1 on an invalid start.
  - RUN → IDLE at the end of a period, when the burst is complete or `enable_i` is low.
- Start: `enable_i` is 1 and was 0 in the previous cycle, while in IDLE. The start edge is ignored outside IDLE.
- On start, `period_i`, `count_i`, `acq_delay_i` and `acq_len_i` are latched. Input changes during RUN are ignored.
- Config is valid when all of these hold; otherwise the start is rejected:
  - `period_i` ≥ 2
  - `acq_len_i` ≥ 1
  - `acq_delay_i + acq_len_i` ≤ `period_i`, compared at CNT_W+1 bits so the sum cannot overflow
- `cfg_err_o` is sticky. It is cleared only by reset or by the next valid start.
- In RUN, the phase counter `p` runs 0…period−1 and wraps to 0.
  - `signal_start_o` = 1 exactly when `p`=0.
  - `acq_gate_o` = 1 for `acq_delay` ≤ `p` < `acq_delay+acq_len`.
- `trace_idx_o` is 0 for the first trigger and increments by 1 at every subsequent `p`=0. It is valid in the same cycle as `signal_start_o` and holds until the next trigger. It wraps modulo 2^CNT_W in continuous mode.
- Finite burst: after the `count`-th period completes (`p`=period−1 of trace `count`−1):
  - `done_o` = 1 for one cycle and `busy_o` = 0, both in the following cycle.
  - No restart until a new `enable_i` rising edge, even if `enable_i` stays high.
- Stop: when `enable_i` goes low during RUN, the current period finishes, including the full gate, and then the block returns to IDLE with no `done_o` and no further trigger.
- If `enable_i` goes low and back high within one period, the run continues. The re-rise is not a start edge because the block is not in IDLE.

## Timing
- Start edge sampled at clock k (`enable_i`=1 at k, 0 at k−1). At k+1: `busy_o`=1, `signal_start_o`=1, `trace_idx_o`=0.
- Trigger n (0-based) occurs at k+1+n·period.
- The gate of trace n is high in cycles k+1+n·period+delay … k+n·period+delay+len, inclusive.
- With `acq_delay`=0, `acq_gate_o` rises in the same cycle as `signal_start_o`.
- Finite burst: `done_o`=1 and `busy_o`=0 at k+1+count·period.
- Invalid start at k: `cfg_err_o`=1 at k+1; `busy_o` and `signal_start_o` remain 0.
- All outputs are registered. Minimum spacing between `signal_start_o` pulses is 2 cycles, so the downstream edge detector always sees a 0 between triggers.

## Test plan
- Reset mid-run at an arbitrary cycle → all outputs 0 in the next cycle; no `done_o`; a new start edge then begins at `trace_idx_o`=0.
- period=10, count=3, delay=2, len=5, start edge at k:
  - `signal_start_o` at k+1, k+11, k+21
  - `acq_gate_o` high k+3…k+7, k+13…k+17, k+23…k+27
  - `trace_idx_o` 0, 1, 2
  - `done_o` and `busy_o`=0 at k+31
- Invalid configs, each rejected with `cfg_err_o`=1 and no trigger:
  - period=1
  - len=0
  - delay=6, len=5, period=10
  - delay=0xFFFF_FFFF, len=2, period=10 (overflow case)
  - A following valid start clears `cfg_err_o`.
- Continuous mode, count=0, period=4, delay=0, len=4:
  - Gate constantly high, trigger every 4 cycles.
  - Drop `enable_i` at `p`=1 → the period completes, return to IDLE after `p`=3, no `done_o`.
- `enable_i` held high after a burst completes → no new trigger. Toggle `enable_i` 1→0→1 → a new run starts with `trace_idx_o`=0.
- Change `period_i` and `acq_delay_i` mid-run → trigger and gate timing unchanged until the next start.

Source files
------------

// File: rtl/pulse_trigger_sequencer.sv
// Periodic probe-pulse trigger with matching ADC acquisition gate and trace index.
// All outputs registered; a run starts one cycle after the enable rising edge; no backpressure.
module pulse_trigger_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk_adc_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W-1:0] acq_delay_i,
    input  logic [CNT_W-1:0] acq_len_i,
    output logic             signal_start_o,
    output logic             acq_gate_o,
    output logic [CNT_W-1:0] trace_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             enable_q;
    logic [CNT_W-1:0] p_q, p_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W:0]   gate_end_q, gate_end_d;
    logic             start_q, start_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             start_edge;
    logic             cfg_valid;
    logic [CNT_W:0]   cfg_sum;
    logic [CNT_W-1:0] p_inc;
    logic             period_end;
    logic             last_trace;

    assign start_edge = enable_i && !enable_q;
    // Sum is formed one bit wider so a huge delay cannot wrap into a small value.
    assign cfg_sum    = {1'b0, acq_delay_i} + {1'b0, acq_len_i};
    assign cfg_valid  = (period_i >= CNT_W'(2)) && (acq_len_i != '0) &&
                        (cfg_sum <= {1'b0, period_i});
    assign p_inc      = p_q + CNT_W'(1);
    assign period_end = (p_q == period_q - CNT_W'(1));
    assign last_trace = (count_q != '0) && (idx_q == count_q - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        idx_d      = idx_q;
        period_d   = period_q;
        count_d    = count_q;
        delay_d    = delay_q;
        gate_end_d = gate_end_q;
        start_d    = 1'b0;
        gate_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    if (cfg_valid) begin
                        state_d    = RUN;
                        p_d        = '0;
                        idx_d      = '0;
                        period_d   = period_i;
                        count_d    = count_i;
                        delay_d    = acq_delay_i;
                        gate_end_d = cfg_sum;
                        start_d    = 1'b1;
                        gate_d     = (acq_delay_i == '0);
                        busy_d     = 1'b1;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (period_end) begin
                    // Burst completion takes priority; a stop request only suppresses the next trigger.
                    if (last_trace) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (!enable_i) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        p_d     = '0;
                        idx_d   = idx_q + CNT_W'(1);
                        start_d = 1'b1;
                        gate_d  = (delay_q == '0);
                    end
                end else begin
                    p_d    = p_inc;
                    gate_d = (p_inc >= delay_q) && ({1'b0, p_inc} < gate_end_q);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_adc_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            p_q        <= '0;
            idx_q      <= '0;
            period_q   <= '0;
            count_q    <= '0;
            delay_q    <= '0;
            gate_end_q <= '0;
            start_q    <= 1'b0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_i;
            p_q        <= p_d;
            idx_q      <= idx_d;
            period_q   <= period_d;
            count_q    <= count_d;
            delay_q    <= delay_d;
            gate_end_q <= gate_end_d;
            start_q    <= start_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign signal_start_o = start_q;
    assign acq_gate_o     = gate_q;
    assign trace_idx_o    = idx_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign cfg_err_o      = err_q;

endmodule

// File: tb/tb_pulse_trigger_sequencer.sv
// Directed bench for pulse_trigger_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_pulse_trigger_sequencer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [31:0] period_i, count_i, acq_delay_i, acq_len_i;
    logic        signal_start_o, acq_gate_o, busy_o, done_o, cfg_err_o;
    logic [31:0] trace_idx_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pulse_trigger_sequencer #(.CNT_W(32)) dut (
        .clk_adc_i      (clk),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .period_i       (period_i),
        .count_i        (count_i),
        .acq_delay_i    (acq_delay_i),
        .acq_len_i      (acq_len_i),
        .signal_start_o (signal_start_o),
        .acq_gate_o     (acq_gate_o),
        .trace_idx_o    (trace_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Expected {start, gate, busy, done, idx} in the t-th cycle after the start edge (t >= 1).
    function automatic logic [35:0] exp_at(int t, int per, int cnt, int d, int l);
        int n = (t - 1) / per;
        int p = (t - 1) % per;
        logic [35:0] r = '0;
        if (cnt == 0 || n < cnt) begin
            r[35]   = (p == 0);
            r[34]   = (p >= d) && (p < d + l);
            r[33]   = 1'b1;
            r[31:0] = 32'(n);
        end else if (t == 1 + cnt * per) begin
            r[32] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [35:0] obs();
        return {signal_start_o, acq_gate_o, busy_o, done_o, trace_idx_o};
    endfunction

    task automatic arm(int per, int cnt, int d, int l);
        enable_i = 1'b0;
        step();
        period_i    = 32'(per);
        count_i     = 32'(cnt);
        acq_delay_i = 32'(d);
        acq_len_i   = 32'(l);
        enable_i    = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        enable_i = 1'b0;
        period_i = 32'd10; count_i = 32'd1; acq_delay_i = 32'd0; acq_len_i = 32'd1;
        repeat (3) step();
        vectors++;
        if ({obs(), cfg_err_o} !== 37'b0) begin
            errors++;
            $display("FAIL reset_state got %h cfg_err=%b required all zero", obs(), cfg_err_o);
        end
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_burst();
        logic [35:0] e, o;
        arm(10, 3, 2, 5);
        for (int t = 1; t <= 42; t++) begin
            step();
            e = exp_at(t, 10, 3, 2, 5);
            o = obs();
            vectors++;
            if (o[35:32] !== e[35:32] || (e[33] && o[31:0] !== e[31:0])) begin
                errors++;
                $display("FAIL burst t=%0d got %h required %h", t, o, e);
            end
        end
    endtask

    task automatic test_invalid();
        int per[4] = '{1, 10, 10, 10};
        int dly[4] = '{0, 0, 6, -1};
        int len[4] = '{1, 0, 5, 2};
        for (int i = 0; i < 4; i++) begin
            arm(per[i], 2, dly[i], len[i]);
            for (int c = 0; c < 4; c++) begin
                step();
                vectors++;
                if ({cfg_err_o, busy_o, signal_start_o, acq_gate_o} !== 4'b1000) begin
                    errors++;
                    $display("FAIL invalid_cfg%0d c=%0d got err=%b busy=%b start=%b gate=%b required err=1 others 0",
                             i, c, cfg_err_o, busy_o, signal_start_o, acq_gate_o);
                end
            end
        end
        arm(3, 1, 0, 1);
        step();
        vectors++;
        if ({cfg_err_o, busy_o, signal_start_o, trace_idx_o} !== {3'b011, 32'd0}) begin
            errors++;
            $display("FAIL valid_clears_err got err=%b busy=%b start=%b idx=%0d required err=0 busy=1 start=1 idx=0",
                     cfg_err_o, busy_o, signal_start_o, trace_idx_o);
        end
        repeat (4) step();
    endtask

    task automatic test_midrun_change();
        logic [35:0] e, o;
        arm(6, 2, 1, 2);
        for (int t = 1; t <= 16; t++) begin
            step();
            if (t == 3) begin
                period_i = 32'd3; acq_delay_i = 32'd0; acq_len_i = 32'd1; count_i = 32'd7;
            end
            e = exp_at(t, 6, 2, 1, 2);
            o = obs();
            vectors++;
            if (o[35:32] !== e[35:32] || (e[33] && o[31:0] !== e[31:0])) begin
                errors++;
                $display("FAIL midrun_change t=%0d got %h required %h", t, o, e);
            end
        end
    endtask

    task automatic test_continuous_stop();
        logic [35:0] e, o;
        arm(4, 0, 0, 4);
        for (int t = 1; t <= 22; t++) begin
            step();
            e = (t <= 16) ? exp_at(t, 4, 0, 0, 4) : 36'b0;
            o = obs();
            vectors++;
            if (o[35:32] !== e[35:32] || (e[33] && o[31:0] !== e[31:0])) begin
                errors++;
                $display("FAIL continuous_stop t=%0d got %h required %h", t, o, e);
            end
            if (t == 14) enable_i = 1'b0;
        end
    endtask

    task automatic test_reenable_in_period();
        logic [35:0] e, o;
        arm(4, 0, 1, 2);
        for (int t = 1; t <= 16; t++) begin
            step();
            e = exp_at(t, 4, 0, 1, 2);
            o = obs();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL reenable_in_period t=%0d got %h required %h", t, o, e);
            end
            if (t == 6) enable_i = 1'b0;
            if (t == 7) enable_i = 1'b1;
        end
        enable_i = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset_midrun();
        logic [35:0] e, o;
        arm(5, 4, 1, 2);
        repeat (8) step();
        reset_i  = 1'b1;
        enable_i = 1'b0;
        step();
        vectors++;
        if ({obs(), cfg_err_o} !== 37'b0) begin
            errors++;
            $display("FAIL reset_midrun got %h cfg_err=%b required all zero", obs(), cfg_err_o);
        end
        reset_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if ({signal_start_o, busy_o, done_o} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle c=%0d got start=%b busy=%b done=%b required 0",
                         c, signal_start_o, busy_o, done_o);
            end
        end
        enable_i = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            e = exp_at(t, 5, 4, 1, 2);
            o = obs();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL restart_after_reset t=%0d got %h required %h", t, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_invalid();
        test_midrun_change();
        test_continuous_stop();
        test_reenable_in_period();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
